// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AES core adapter.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned AES_BYTE_W      = 8;
  localparam int unsigned AES_BLOCK_W     = AES_BLOCK_BYTES * AES_BYTE_W;

  typedef enum logic [2:0] {
    RSTC,
    IDLE,
    FEED,
    COLLECT,
    OUT
  } adapter_state_t;

endpackage

// File: rtl/aes_stream_adapter.sv
// Serialises a key/plaintext block into the byte-serial AES core and gathers
// the 16 ciphertext bytes back into one block, resetting the core between blocks.
module aes_stream_adapter
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_key,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   err,
  output logic                   core_rst,
  output logic                   core_en,
  output logic [AES_BYTE_W-1:0]  core_key_byte,
  output logic [AES_BYTE_W-1:0]  core_state_byte,
  input  logic                   core_ready,
  input  logic [AES_BYTE_W-1:0]  core_out_byte
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  adapter_state_t state, state_d;

  logic                   boot;
  logic [AES_BLOCK_W-1:0] key_sr, pt_sr, ct_sr;
  logic [4:0]             byte_cnt, byte_inc;
  logic                   byte_done;
  logic [CW-1:0]          cyc_cnt, cyc_inc;
  logic                   timeout_hit;

  always_comb begin
    state_d     = state;
    byte_inc    = byte_cnt + 5'd1;
    byte_done   = (byte_inc == 5'(AES_BLOCK_BYTES));
    cyc_inc     = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CW'(1);
    timeout_hit = (cyc_inc >= CW'(TIMEOUT));
    unique case (state)
      RSTC:    if (!boot) state_d = IDLE;
      IDLE:    if (in_valid) state_d = FEED;
      FEED:    if (byte_done) state_d = COLLECT;
      // the 16th byte wins over a coincident timeout
      COLLECT: begin
        if (core_ready && byte_done) state_d = OUT;
        else if (timeout_hit)        state_d = RSTC;
      end
      OUT:     if (out_ready) state_d = RSTC;
      default: state_d = RSTC;
    endcase
  end

  // boot holds RSTC for one full cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RSTC;
      boot      <= 1'b1;
      key_sr    <= '0;
      pt_sr     <= '0;
      ct_sr     <= '0;
      byte_cnt  <= '0;
      cyc_cnt   <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      core_rst  <= 1'b1;
      core_en   <= 1'b0;
    end else begin
      state     <= state_d;
      boot      <= 1'b0;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
      core_rst  <= (state_d == RSTC);
      core_en   <= (state_d == FEED) || (state_d == COLLECT);
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            key_sr   <= in_key;
            pt_sr    <= in_block;
            ct_sr    <= '0;
            byte_cnt <= '0;
          end
        end
        FEED: begin
          key_sr   <= {key_sr[AES_BLOCK_W-AES_BYTE_W-1:0], {AES_BYTE_W{1'b0}}};
          pt_sr    <= {pt_sr[AES_BLOCK_W-AES_BYTE_W-1:0], {AES_BYTE_W{1'b0}}};
          byte_cnt <= byte_done ? '0 : byte_inc;
          cyc_cnt  <= '0;
        end
        COLLECT: begin
          cyc_cnt <= cyc_inc;
          if (core_ready) begin
            ct_sr    <= {ct_sr[AES_BLOCK_W-AES_BYTE_W-1:0], core_out_byte};
            byte_cnt <= byte_inc;
          end
          if (timeout_hit && !(core_ready && byte_done)) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign core_key_byte   = key_sr[AES_BLOCK_W-1 -: AES_BYTE_W];
  assign core_state_byte = pt_sr[AES_BLOCK_W-1 -: AES_BYTE_W];
  assign out_block       = ct_sr;

endmodule
